// File: rtl/core_pkg.sv
// Shared definitions for the MIPS core front end: PC-select encoding,
// fetch FSM states and the default reset fetch address.
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] PCSEL_SEQ = 3'b000;
  localparam logic [2:0] PCSEL_BR  = 3'b001;
  localparam logic [2:0] PCSEL_J   = 3'b010;
  localparam logic [2:0] PCSEL_REG = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_JMP,
    NPC_REG
  } npc_kind_t;

  // j/jal and jr/jalr each occupy a pair of codes; 11x falls back to sequential.
  function automatic npc_kind_t decode_pcsel(input logic [2:0] sel);
    if (sel == PCSEL_BR)
      return NPC_BR;
    if (sel[2:1] == PCSEL_J[2:1])
      return NPC_JMP;
    if (sel[2:1] == PCSEL_REG[2:1])
      return NPC_REG;
    return NPC_SEQ;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target mux for the instruction sitting in ID.
// Produces the redirect target and whether the PC select redirects at all.
module npc_calc
  import core_pkg::*;
(
  input  logic [2:0]  pc_src_i,
  input  logic [31:0] id_pc_plus4_i,
  input  logic [31:0] id_inst_i,
  input  logic [31:0] rs_value_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  npc_kind_t          kind;
  logic signed [31:0] br_off;
  logic               unused_bits;

  assign kind        = decode_pcsel(pc_src_i);
  assign br_off      = signed'({{14{id_inst_i[15]}}, id_inst_i[15:0], 2'b00});
  assign unused_bits = ^{id_inst_i[31:26], rs_value_i[1:0]};

  always_comb begin
    redirect_o = 1'b1;
    target_o   = id_pc_plus4_i;
    case (kind)
      NPC_BR:  target_o = id_pc_plus4_i + unsigned'(br_off);
      NPC_JMP: target_o = {id_pc_plus4_i[31:28], id_inst_i[25:0], 2'b00};
      NPC_REG: target_o = {rs_value_i[31:2], 2'b00};
      default: redirect_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. Issues one imem
// request at a time and redirects on the ID-stage PC select (no delay slot).
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_src,
  input  logic [31:0] rs_value,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [5:0]  id_func,
  output logic        id_b_code,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_fetch_q, pc_fetch_d;
  logic         squash_q, squash_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0]  hold_inst_q, hold_pc_q;
  logic         hold_capture, load_mem, load_hold;
  logic         consume, redirect, npc_redirect;
  logic [31:0]  npc_target;

  npc_calc u_npc (
    .pc_src_i     (pc_src),
    .id_pc_plus4_i(id_pc_plus4_q),
    .id_inst_i    (id_inst_q),
    .rs_value_i   (rs_value),
    .redirect_o   (npc_redirect),
    .target_o     (npc_target)
  );

  assign consume  = id_valid_q & ~stall;
  assign redirect = consume & npc_redirect;

  always_comb begin : fsm_next
    state_d      = state_q;
    pc_fetch_d   = pc_fetch_q;
    squash_d     = squash_q;
    load_mem     = 1'b0;
    load_hold    = 1'b0;
    hold_capture = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        state_d = WAIT;
        // The request already on the bus targets the old path; kill its data.
        if (redirect) begin
          pc_fetch_d = npc_target;
          squash_d   = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          if (squash_q || redirect) begin
            squash_d = 1'b0;
            if (redirect)
              pc_fetch_d = npc_target;
          end else if (!id_valid_q || consume) begin
            load_mem   = 1'b1;
            pc_fetch_d = pc_fetch_q + 32'd4;
          end else begin
            hold_capture = 1'b1;
            pc_fetch_d   = pc_fetch_q + 32'd4;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          pc_fetch_d = npc_target;
          squash_d   = 1'b1;
        end
      end
      HOLD: begin
        // pc_fetch already points past the buffered word.
        if (redirect) begin
          pc_fetch_d = npc_target;
          state_d    = REQ;
        end else if (consume) begin
          load_hold = 1'b1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : ifid_next
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    if (load_mem) begin
      id_valid_d    = 1'b1;
      id_inst_d     = imem_rdata;
      id_pc_d       = pc_fetch_q;
      id_pc_plus4_d = pc_fetch_q + 32'd4;
    end else if (load_hold) begin
      id_valid_d    = 1'b1;
      id_inst_d     = hold_inst_q;
      id_pc_d       = hold_pc_q;
      id_pc_plus4_d = hold_pc_q + 32'd4;
    end else if (consume) begin
      id_valid_d = 1'b0;
    end
  end

  assign imem_req_d  = (state_d == REQ);
  assign imem_addr_d = imem_req_d ? pc_fetch_d : imem_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_fetch_q    <= RESET_PC;
      squash_q      <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= 32'd0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_fetch_q    <= pc_fetch_d;
      squash_q      <= squash_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_capture) begin
      hold_inst_q <= imem_rdata;
      hold_pc_q   <= pc_fetch_q;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_func     = id_inst_q[5:0];
  assign id_b_code   = id_inst_q[16];
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic,
// checked against an architectural program-flow model and a latency memory.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  pc_src = 3'd0;
  logic [31:0] rs_value = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [5:0]  id_func;
  logic        id_b_code;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_src     (pc_src),
    .rs_value   (rs_value),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_func    (id_func),
    .id_b_code  (id_b_code),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [2:0]  pcsel_at [logic [31:0]];
  int          mem_cnt = 0;
  int          mem_lat_dir = 1;
  logic [31:0] mem_addr_l = 32'd0;
  bit          rand_mode = 1'b0;
  logic [31:0] exp_pc = RST_PC;
  int          reqs = 0;
  logic [31:0] last_req_addr = 32'd0;
  logic [31:0] req_hist [$];
  logic [31:0] watch_pc = 32'hFFFF_FFFF;
  bit          watch_hit = 1'b0;
  logic [31:0] stall_pc = 32'hFFFF_FFFF;
  int          stall_left = 0;
  bit          frz = 1'b0;
  logic [31:0] frz_inst, frz_pc, frz_pc4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a))
      return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Architectural successor of the instruction at pc under the given select.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic [2:0] sel, input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    case (sel)
      3'd1: begin
        off = $signed(inst[15:0]);
        return seq + 32'(off * 4);
      end
      3'd2, 3'd3: return (seq & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
      3'd4, 3'd5: return rs & 32'hFFFF_FFFC;
      default:    return seq;
    endcase
  endfunction

  task automatic cycle();
    logic [31:0] w;
    logic [2:0]  sel;
    bit          st;
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(mem_addr_l);
      end
    end
    if (imem_req) begin
      chk("one_outstanding", 32'(mem_cnt), 32'd0);
      chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      mem_addr_l    = imem_addr;
      mem_cnt       = rand_mode ? int'($urandom_range(1, 3)) : mem_lat_dir;
      reqs++;
      last_req_addr = imem_addr;
      req_hist.push_back(imem_addr);
    end
    if (frz) begin
      chk("stall_hold_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_hold_inst", id_inst, frz_inst);
      chk("stall_hold_pc", id_pc, frz_pc);
      chk("stall_hold_pc4", id_pc_plus4, frz_pc4);
    end
    frz = 1'b0;
    if (rand_mode) begin
      st       = ($urandom_range(0, 3) == 0);
      sel      = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(0, 7));
      rs_value = $urandom;
    end else begin
      st = id_valid && (id_pc == stall_pc) && (stall_left > 0);
      if (st)
        stall_left--;
      sel = (id_valid && pcsel_at.exists(id_pc)) ? pcsel_at[id_pc] : 3'd0;
    end
    stall  = st;
    pc_src = sel;
    if (id_valid && !st) begin
      w = memword(exp_pc);
      chk("id_pc", id_pc, exp_pc);
      chk("id_inst", id_inst, w);
      chk("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
      chk("id_func", {26'd0, id_func}, {26'd0, w[5:0]});
      chk("id_b_code", {31'd0, id_b_code}, {31'd0, w[16]});
      if (!rand_mode && pcsel_at.exists(id_pc))
        pcsel_at.delete(id_pc);
      if (id_pc == watch_pc)
        watch_hit = 1'b1;
      exp_pc = model_next(exp_pc, w, sel, rs_value);
    end else if (id_valid) begin
      frz      = 1'b1;
      frz_inst = id_inst;
      frz_pc   = id_pc;
      frz_pc4  = id_pc_plus4;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    pc_src      = 3'd0;
    imem_rvalid = 1'b0;
    mem_cnt     = 0;
    frz         = 1'b0;
    exp_pc      = RST_PC;
    reqs        = 0;
    req_hist.delete();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_redirect(input string tag, input logic [31:0] pc, input logic [2:0] sel,
                             input logic [31:0] exp_addr);
    int n;
    int r0;
    pcsel_at[pc] = sel;
    watch_pc     = pc;
    watch_hit    = 1'b0;
    n = 0;
    while (!watch_hit && n < 60) begin
      cycle();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, watch_hit}, 32'd1);
    r0 = reqs;
    n  = 0;
    while (reqs == r0 && n < 60) begin
      cycle();
      n++;
    end
    chk(tag, (reqs == r0) ? 32'hDEAD_BEEF : last_req_addr, exp_addr);
  endtask

  task automatic wait_id(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!id_valid && n < 60) begin
      cycle();
      n++;
    end
    chk(tag, id_valid ? id_pc : 32'hDEAD_BEEF, exp);
  endtask

  initial begin
    int n;
    int r_s;
    mem[32'h0000_0000] = 32'h2008_0005;
    mem[32'h0000_0010] = 32'h1000_FFFF;
    mem[32'h3000_0040] = 32'h0800_0100;
    mem[32'h0000_123C] = 32'h1000_0010;
    #2;
    do_reset();

    n = 0;
    while (!id_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("rel_req_count", 32'(req_hist.size()), 32'd2);
    chk("rel_req0", (req_hist.size() >= 2) ? req_hist[0] : 32'hDEAD_BEEF, 32'h0);
    chk("rel_req1", (req_hist.size() >= 2) ? req_hist[1] : 32'hDEAD_BEEF, 32'h4);
    chk("rel_inst", id_inst, 32'h2008_0005);
    chk("rel_pc", id_pc, 32'h0);
    chk("rel_pc4", id_pc_plus4, 32'h4);
    chk("rel_func", {26'd0, id_func}, 32'h5);

    go_redirect("branch_target", 32'h10, 3'b001, 32'h10);
    wait_id("branch_no_leak", 32'h10);
    rs_value = 32'h3000_0043;
    go_redirect("reg_jump_hi", 32'h14, 3'b100, 32'h3000_0040);
    go_redirect("jump_target", 32'h3000_0040, 3'b010, 32'h3000_0400);
    rs_value = 32'h0000_1237;
    go_redirect("reg_jump", 32'h3000_0400, 3'b100, 32'h0000_1234);

    stall_pc   = 32'h1234;
    stall_left = 5;
    wait_id("stall_entry", 32'h1234);
    r_s = reqs;
    n   = 0;
    while (stall_left > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("stall_no_req", 32'(reqs), 32'(r_s));
    chk("stall_id_pc", id_pc, 32'h1234);
    cycle();
    cycle();
    chk("hold_release_pc", id_pc, 32'h1238);
    chk("hold_release_inst", id_inst, memword(32'h1238));
    chk("hold_next_req", last_req_addr, 32'h123C);
    chk("hold_one_req", 32'(reqs), 32'(r_s + 1));

    mem_lat_dir = 3;
    stall_pc    = 32'h123C;
    stall_left  = 1;
    go_redirect("wait_redirect", 32'h123C, 3'b001, 32'h1280);
    wait_id("squash_no_leak", 32'h1280);
    cycle();
    do_reset();
    n = 0;
    while (reqs == 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("restart_pc", (reqs == 0) ? 32'hDEAD_BEEF : last_req_addr, RST_PC);

    rand_mode = 1'b1;
    repeat (4000) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
